// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the round-robin arbitrated shared register.
package shared_reg_arb_pkg;

    // Two-state write handshake: IDLE accepts a request, ACK holds the pulse for one cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    localparam int NREQ   = 4;
    localparam int WCNT_W = 8;
    localparam int IDX_W  = 2;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/shared_reg_arb_rr_pick4.sv
// Combinational round-robin picker: searches upward from (last+1) mod 4 with wrap.
module rr_pick4
    import shared_reg_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Candidate k is the k-th index in priority order after the last winner.
    logic [IDX_W-1:0] cand [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand[gi] = last + IDX_W'(gi + 1);
        end
    endgenerate

    // Scan lowest priority first so the highest-priority requester overwrites.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arb.sv
// Four-requester shared register with round-robin write arbitration,
// one-cycle ACK pulse, synchronous clear and a wrapping write counter.
module shared_reg_arb
    import shared_reg_arb_pkg::*;
#(
    parameter int               width = 1,
    parameter logic [width-1:0] init  = '0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ*width-1:0]  D_IN,
    input  logic                   CLR,
    output logic [NREQ-1:0]        ACK,
    output logic                   BUSY,
    output logic [width-1:0]       Q_OUT,
    output logic [WCNT_W-1:0]      WCNT
);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   last_reg;
    logic [NREQ-1:0]    ack_reg;
    logic [WCNT_W-1:0]  wcnt_reg;
    logic [width-1:0]   q_reg;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               grant;
    logic               q_en;
    logic [width-1:0]   q_d;

    rr_pick4 u_pick (
        .req   (REQ),
        .last  (last_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state logic: grant only from IDLE, and clear takes precedence over a request.
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!CLR && pick_valid) begin
                    grant      = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state, last winner and the registered ACK pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
            last_reg  <= IDX_W'(NREQ - 1);
            ack_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= grant ? onehot4(pick_idx) : '0;
            if (grant) begin
                last_reg <= pick_idx;
            end
        end
    end

    // Register load source: clear value wins over winner data.
    assign q_en = CLR | grant;
    assign q_d  = CLR ? init : D_IN[pick_idx*width +: width];

    // Shared register storage: asynchronous reset plus load enable.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_reg <= init;
        end else if (q_en) begin
            q_reg <= q_d;
        end
    end

    // Completed-write counter; wraps naturally and is untouched by clear.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wcnt_reg <= '0;
        end else if (grant) begin
            wcnt_reg <= wcnt_reg + 8'd1;
        end
    end

`ifndef BSV_NO_INITIAL_BLOCKS
    // Simulation-only power-up pattern so un-reset state is recognisable.
    initial begin
        for (int i = 0; i < width; i++) begin
            q_reg[i] = (i % 2) == 1;
        end
        wcnt_reg = 8'hAA;
    end
`endif

    assign ACK   = ack_reg;
    assign BUSY  = (state_reg == ST_ACK);
    assign Q_OUT = q_reg;
    assign WCNT  = wcnt_reg;

endmodule

// File: tb/tb_shared_reg_arb.sv
// Directed self-checking bench for shared_reg_arb (width=8, init=8'h5A).
module tb_shared_reg_arb;

    localparam int          W    = 8;
    localparam logic [7:0]  INIT = 8'h5A;

    logic          CLK;
    logic          RST_N;
    logic [3:0]    REQ;
    logic [4*W-1:0] D_IN;
    logic          CLR;
    logic [3:0]    ACK;
    logic          BUSY;
    logic [W-1:0]  Q_OUT;
    logic [7:0]    WCNT;

    int n_checks = 0;
    int n_errors = 0;

    shared_reg_arb #(
        .width (W),
        .init  (INIT)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .D_IN  (D_IN),
        .CLR   (CLR),
        .ACK   (ACK),
        .BUSY  (BUSY),
        .Q_OUT (Q_OUT),
        .WCNT  (WCNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        D_IN = {d3, d2, d1, d0};
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ack_e, input logic busy_e,
                           input logic [7:0] q_e, input logic [7:0] wcnt_e);
        check({tag, ".ack"},  32'(ACK),   32'(ack_e));
        check({tag, ".busy"}, 32'(BUSY),  32'(busy_e));
        check({tag, ".q"},    32'(Q_OUT), 32'(q_e));
        check({tag, ".wcnt"}, 32'(WCNT),  32'(wcnt_e));
        $display("[%0t] %s: REQ=%b ACK=%b BUSY=%b Q=%h WCNT=%0d", $time, tag, REQ, ACK, BUSY, Q_OUT, WCNT);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    logic [3:0] exp_ack [5];
    logic [7:0] exp_q   [5];

    initial begin
        RST_N = 1'b0;
        REQ   = '0;
        CLR   = 1'b0;
        set_din(8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state
        repeat (2) @(negedge CLK);
        chk_all("in_reset", 4'b0000, 1'b0, INIT, 8'd0);
        RST_N = 1'b1;

        // Basic write from requester 0 right after reset release
        REQ = 4'b0001;
        set_din(8'h05, 8'h00, 8'h00, 8'h00);
        @(negedge CLK);
        chk_all("wr0_grant", 4'b0001, 1'b1, 8'h05, 8'd1);
        REQ = 4'b0000;
        @(negedge CLK);
        chk_all("wr0_done", 4'b0000, 1'b0, 8'h05, 8'd1);

        // Fairness with all four requesting continuously
        do_reset();
        set_din(8'h11, 8'h22, 8'h33, 8'h44);
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_q   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk_all($sformatf("rr%0d_grant", i), exp_ack[i], 1'b1, exp_q[i], 8'(i + 1));
            @(negedge CLK);
            chk_all($sformatf("rr%0d_gap", i), 4'b0000, 1'b0, exp_q[i], 8'(i + 1));
        end
        REQ = 4'b0000;

        // Load 0x33 through requester 1 (last winner was 0)
        set_din(8'h00, 8'h33, 8'h77, 8'h00);
        REQ = 4'b0010;
        @(negedge CLK);
        chk_all("pre_clr", 4'b0010, 1'b1, 8'h33, 8'd6);
        REQ = 4'b0000;
        @(negedge CLK);

        // Clear beats a simultaneous request in IDLE
        REQ = 4'b0100;
        CLR = 1'b1;
        @(negedge CLK);
        chk_all("clr_wins", 4'b0000, 1'b0, INIT, 8'd6);
        CLR = 1'b0;
        @(negedge CLK);
        chk_all("after_clr", 4'b0100, 1'b1, 8'h77, 8'd7);
        REQ = 4'b0000;
        @(negedge CLK);

        // Clear during ACK state still ends the pulse and reloads init
        set_din(8'h10, 8'h00, 8'h00, 8'h00);
        REQ = 4'b0001;
        @(negedge CLK);
        chk_all("clr_ack_grant", 4'b0001, 1'b1, 8'h10, 8'd8);
        REQ = 4'b0000;
        CLR = 1'b1;
        @(negedge CLK);
        chk_all("clr_in_ack", 4'b0000, 1'b0, INIT, 8'd8);
        CLR = 1'b0;

        // Requests are ignored in ACK state
        set_din(8'hA1, 8'h00, 8'h00, 8'hB3);
        REQ = 4'b0001;
        @(negedge CLK);
        chk_all("ign_grant0", 4'b0001, 1'b1, 8'hA1, 8'd9);
        REQ = 4'b1000;
        @(negedge CLK);
        chk_all("ign_in_ack", 4'b0000, 1'b0, 8'hA1, 8'd9);
        @(negedge CLK);
        chk_all("ign_grant3", 4'b1000, 1'b1, 8'hB3, 8'd10);
        REQ = 4'b0000;
        @(negedge CLK);

        // Drive WCNT up to 255 with 245 back-to-back writes, then wrap
        set_din(8'h01, 8'h00, 8'hC4, 8'h00);
        REQ = 4'b0001;
        repeat (490) @(negedge CLK);
        REQ = 4'b0000;
        chk_all("wcnt_255", 4'b0000, 1'b0, 8'h01, 8'd255);
        REQ = 4'b0100;
        @(negedge CLK);
        chk_all("wcnt_wrap", 4'b0100, 1'b1, 8'hC4, 8'd0);
        REQ = 4'b0000;
        @(negedge CLK);

        // Asynchronous reset while BUSY
        set_din(8'h00, 8'h00, 8'h00, 8'hD3);
        REQ = 4'b1000;
        @(negedge CLK);
        chk_all("pre_rst", 4'b1000, 1'b1, 8'hD3, 8'd1);
        REQ = 4'b0000;
        #2 RST_N = 1'b0;
        #1;
        chk_all("async_rst", 4'b0000, 1'b0, INIT, 8'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk_all("post_rst", 4'b0000, 1'b0, INIT, 8'd0);

        // First arbitration after reset gives requester 0 priority
        set_din(8'hE0, 8'hE1, 8'h00, 8'h00);
        REQ = 4'b0011;
        @(negedge CLK);
        chk_all("first_arb", 4'b0001, 1'b1, 8'hE0, 8'd1);
        REQ = 4'b0000;
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_arb.md
SHARED_REG_ARB -- requirements
Module: shared_reg_arb

Interface
REQ-001 SHALL have parameter width, default 1, data width of the shared register.
REQ-002 SHALL have parameter init, default all-zero of width bits, reset and clear value of the register.
REQ-003 SHALL have port CLK, input, 1, rising-edge clock.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port REQ, input, 4, per-requester write request; bit i belongs to requester i.
REQ-006 SHALL have port D_IN, input, 4*width, packed write data; slice i is [i*width +: width].
REQ-007 SHALL have port CLR, input, 1, synchronous clear of the register to init.
REQ-008 SHALL have port ACK, output, 4, one-hot write-done pulse.
REQ-009 SHALL have port BUSY, output, 1, high while the FSM is in ACK state.
REQ-010 SHALL have port Q_OUT, output, width, current shared register value.
REQ-011 SHALL have port WCNT, output, 8, count of completed writes.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and ACK.
REQ-013 In IDLE with CLR low and any REQ bit high, SHALL select one winner round-robin, starting at index (last+1) mod 4 and ascending with wrap.
REQ-014 On the same edge, SHALL load Q_OUT with D_IN slice of the winner, set ACK to onehot(winner), set last to winner, increment WCNT, and go to ACK.
REQ-015 In ACK state, SHALL clear ACK to 0 on the next edge and return to IDLE; all REQ bits SHALL be ignored in ACK state.
REQ-016 Write latency SHALL be: REQ sampled at edge N, Q_OUT and ACK valid after edge N; peak throughput SHALL be one write per 2 cycles.
REQ-017 A requester SHALL hold REQ and D_IN stable until it sees its ACK bit; a REQ still high in IDLE after ACK is a new request.
REQ-018 CLR SHALL load Q_OUT with init on the next edge in either state.
REQ-019 If CLR and REQ are both high in IDLE, CLR SHALL win: no grant, no ACK, no WCNT change, last unchanged, and the FSM stays in IDLE.
REQ-020 CLR in ACK state SHALL still clear ACK and return the FSM to IDLE.
REQ-021 WCNT SHALL wrap from 255 to 0; CLR SHALL NOT affect WCNT.
REQ-022 ACK SHALL be registered, never combinational from REQ, and SHALL have at most one bit high.
REQ-023 BUSY SHALL equal (state == ACK), registered.

Reset
REQ-024 RST_N low SHALL asynchronously force Q_OUT=init, ACK=0, BUSY=0, WCNT=0, state=IDLE and last=3, so requester 0 has first priority.
REQ-025 Reset asserted mid-ACK SHALL abort the cycle; no ACK pulse SHALL appear after release.
REQ-026 The first arbitration SHALL occur on the first rising edge after RST_N deasserts with REQ nonzero.
REQ-027 Unless BSV_NO_INITIAL_BLOCKS is defined, a simulation-only initial block SHALL set Q_OUT to the repeating 2'b10 pattern and WCNT to 8'hAA.

Structure
REQ-028 A shared package SHALL hold: FSM state encoding (IDLE=0, ACK=1), NREQ=4, WCNT_W=8.
REQ-029 The round-robin selection SHALL be a sub-module rr_pick4: purely combinational, inputs req[3:0] and last[1:0], outputs valid and idx[1:0].
REQ-030 The Q_OUT storage SHALL be a single always block with the same asynchronous-reset and enable structure as the team's standard enable register.

Verification
REQ-031 Reset: hold RST_N=0 and release; then REQ=4'b0001, D_IN slice0=5 (width=8) -> after 1 edge Q_OUT=5, ACK=0001, BUSY=1; after the next edge ACK=0, WCNT=1.
REQ-032 Fairness: hold REQ=4'b1111 continuously -> ACK sequence is 0001, 0010, 0100, 1000, 0001, one ACK every 2 cycles, and WCNT increments by 1 per ACK.
REQ-033 Clear priority: in IDLE with Q_OUT=0x33, REQ=4'b0100 and CLR=1 -> Q_OUT=init, ACK=0, WCNT unchanged; drop CLR -> requester 2 is granted next edge.
REQ-034 Wrap: preload WCNT to 255 via 255 writes, perform one more write -> WCNT=0 and Q_OUT holds the new data.
REQ-035 Reset mid-op: assert RST_N=0 asynchronously while BUSY=1 -> Q_OUT=init and ACK=0 immediately, before any clock edge; no stale ACK appears after release.
REQ-036 Ignore in ACK: change REQ from 0001 to 1000 during ACK state -> no effect until IDLE; requester 3 is granted on the following edge.
